// File: rtl/turn_scheduler.sv
// turn_scheduler: alternates player/PC shot turns with a per-turn timeout,
// arbitrates one external board lookup per shot and keeps score to a winner.
module turn_scheduler #(
  parameter int TURN_CYCLES = 50_000_000,
  parameter int SHIPS       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p_req,
  input  logic [5:0] p_coord,
  input  logic       pc_req,
  input  logic [5:0] pc_coord,
  output logic       bd_req,
  output logic [5:0] bd_addr,
  output logic       bd_side,
  input  logic       bd_ack,
  input  logic       bd_hit,
  output logic       p_ack,
  output logic       pc_ack,
  output logic       turn,
  output logic       timeout,
  output logic [3:0] hits_p,
  output logic [3:0] hits_pc,
  output logic [1:0] winner,
  output logic [2:0] fsm_state
);

  localparam int             TW      = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0]  T_LOAD  = TW'(TURN_CYCLES - 1);
  localparam logic [3:0]     SHIPS_C = 4'(SHIPS);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    P_TURN    = 3'b001,
    P_LOOK    = 3'b010,
    PC_TURN   = 3'b011,
    PC_LOOK   = 3'b100,
    GAME_OVER = 3'b101
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          bd_req_q;
  logic [5:0]    bd_addr_q;
  logic          bd_side_q;
  logic          p_ack_q;
  logic          pc_ack_q;
  logic          turn_q;
  logic          timeout_q;
  logic [3:0]    hits_p_q;
  logic [3:0]    hits_pc_q;
  logic [1:0]    winner_q;
  logic [3:0]    shot_cnt_s;
  logic [3:0]    hit_cnt_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v == 4'd15) begin
      sat_inc = 4'd15;
    end else begin
      sat_inc = v + 4'd1;
    end
  endfunction

  // Score the current shooter would reach if the pending lookup is a hit
  always_comb begin
    shot_cnt_s = 4'd0;
    if (turn_q) begin
      shot_cnt_s = hits_pc_q;
    end else begin
      shot_cnt_s = hits_p_q;
    end
    hit_cnt_d = sat_inc(shot_cnt_s);
  end

  // Turn FSM with turn timer and every registered output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bd_req_q  <= 1'b0;
      bd_addr_q <= 6'd0;
      bd_side_q <= 1'b0;
      p_ack_q   <= 1'b0;
      pc_ack_q  <= 1'b0;
      turn_q    <= 1'b0;
      timeout_q <= 1'b0;
      hits_p_q  <= 4'd0;
      hits_pc_q <= 4'd0;
      winner_q  <= 2'b00;
    end else begin
      p_ack_q   <= 1'b0;
      pc_ack_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAME_OVER: begin
          if (start) begin
            state_q   <= P_TURN;
            timer_q   <= T_LOAD;
            hits_p_q  <= 4'd0;
            hits_pc_q <= 4'd0;
            winner_q  <= 2'b00;
            turn_q    <= 1'b0;
          end
        end
        P_TURN: begin
          if (p_req) begin
            state_q   <= P_LOOK;
            bd_req_q  <= 1'b1;
            bd_addr_q <= p_coord;
            bd_side_q <= 1'b0;
          end else if (timer_q == '0) begin
            timeout_q <= 1'b1;
            state_q   <= PC_TURN;
            timer_q   <= T_LOAD;
            turn_q    <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        PC_TURN: begin
          if (pc_req) begin
            state_q   <= PC_LOOK;
            bd_req_q  <= 1'b1;
            bd_addr_q <= pc_coord;
            bd_side_q <= 1'b1;
          end else if (timer_q == '0) begin
            timeout_q <= 1'b1;
            state_q   <= P_TURN;
            timer_q   <= T_LOAD;
            turn_q    <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        // In a LOOK state turn_q already identifies the shooter
        P_LOOK, PC_LOOK: begin
          if (bd_ack) begin
            bd_req_q <= 1'b0;
            if (turn_q) begin
              pc_ack_q <= 1'b1;
            end else begin
              p_ack_q <= 1'b1;
            end
            if (bd_hit) begin
              if (turn_q) begin
                hits_pc_q <= hit_cnt_d;
              end else begin
                hits_p_q <= hit_cnt_d;
              end
              if (hit_cnt_d == SHIPS_C) begin
                state_q  <= GAME_OVER;
                winner_q <= turn_q ? 2'b10 : 2'b01;
              end else begin
                state_q <= turn_q ? PC_TURN : P_TURN;
                timer_q <= T_LOAD;
              end
            end else begin
              state_q <= turn_q ? P_TURN : PC_TURN;
              timer_q <= T_LOAD;
              turn_q  <= ~turn_q;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          bd_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bd_req    = bd_req_q;
  assign bd_addr   = bd_addr_q;
  assign bd_side   = bd_side_q;
  assign p_ack     = p_ack_q;
  assign pc_ack    = pc_ack_q;
  assign turn      = turn_q;
  assign timeout   = timeout_q;
  assign hits_p    = hits_p_q;
  assign hits_pc   = hits_pc_q;
  assign winner    = winner_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: a game-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_turn_scheduler;

  localparam int TC = 8;
  localparam int SH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       p_req = 1'b0;
  logic [5:0] p_coord = 6'd0;
  logic       pc_req = 1'b0;
  logic [5:0] pc_coord = 6'd0;
  logic       bd_ack = 1'b0;
  logic       bd_hit = 1'b0;
  logic       bd_req;
  logic [5:0] bd_addr;
  logic       bd_side;
  logic       p_ack;
  logic       pc_ack;
  logic       turn;
  logic       timeout;
  logic [3:0] hits_p;
  logic [3:0] hits_pc;
  logic [1:0] winner;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  turn_scheduler #(.TURN_CYCLES(TC), .SHIPS(SH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p_req(p_req), .p_coord(p_coord), .pc_req(pc_req), .pc_coord(pc_coord),
    .bd_req(bd_req), .bd_addr(bd_addr), .bd_side(bd_side),
    .bd_ack(bd_ack), .bd_hit(bd_hit), .p_ack(p_ack), .pc_ack(pc_ack),
    .turn(turn), .timeout(timeout), .hits_p(hits_p), .hits_pc(hits_pc),
    .winner(winner), .fsm_state(fsm_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Game model: who shoots, whether a lookup is pending, time used in the turn
  bit         m_active = 1'b0;
  bit         m_over   = 1'b0;
  bit         m_who    = 1'b0;
  bit         m_wait   = 1'b0;
  int         m_elapsed = 0;
  int         m_hits[2] = '{0, 0};
  logic       e_bd_req = 1'b0;
  logic [5:0] e_bd_addr = 6'd0;
  logic       e_bd_side = 1'b0;
  logic       e_p_ack = 1'b0;
  logic       e_pc_ack = 1'b0;
  logic       e_timeout = 1'b0;
  logic       e_turn = 1'b0;
  logic [1:0] e_winner = 2'b00;

  function automatic logic [2:0] m_state();
    if (m_over) return 3'd5;
    if (!m_active) return 3'd0;
    if (!m_who) return m_wait ? 3'd2 : 3'd1;
    return m_wait ? 3'd4 : 3'd3;
  endfunction

  task automatic m_reset();
    m_active = 1'b0; m_over = 1'b0; m_who = 1'b0; m_wait = 1'b0; m_elapsed = 0;
    m_hits[0] = 0; m_hits[1] = 0;
    e_bd_req = 1'b0; e_bd_addr = 6'd0; e_bd_side = 1'b0; e_p_ack = 1'b0;
    e_pc_ack = 1'b0; e_timeout = 1'b0; e_turn = 1'b0; e_winner = 2'b00;
  endtask

  task automatic m_step();
    e_p_ack = 1'b0; e_pc_ack = 1'b0; e_timeout = 1'b0;
    if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_over = 1'b0; m_who = 1'b0; m_wait = 1'b0; m_elapsed = 0;
        m_hits[0] = 0; m_hits[1] = 0; e_winner = 2'b00; e_turn = 1'b0;
      end
    end else if (!m_wait) begin
      if ((!m_who && p_req) || (m_who && pc_req)) begin
        m_wait = 1'b1; e_bd_req = 1'b1;
        e_bd_addr = m_who ? pc_coord : p_coord;
        e_bd_side = m_who;
      end else if (m_elapsed == TC - 1) begin
        e_timeout = 1'b1; m_who = !m_who; m_elapsed = 0; e_turn = m_who;
      end else begin
        m_elapsed++;
      end
    end else if (bd_ack) begin
      e_bd_req = 1'b0; m_wait = 1'b0;
      if (m_who) e_pc_ack = 1'b1; else e_p_ack = 1'b1;
      if (bd_hit) begin
        m_hits[m_who] = (m_hits[m_who] < 15) ? m_hits[m_who] + 1 : 15;
        if (m_hits[m_who] == SH) begin
          m_active = 1'b0; m_over = 1'b1; e_winner = m_who ? 2'b10 : 2'b01;
        end else begin
          m_elapsed = 0;
        end
      end else begin
        m_who = !m_who; m_elapsed = 0; e_turn = m_who;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) m_reset();
    else m_step();
  end

  // Every-cycle comparison against the model, away from the rising edge
  initial forever begin
    @(negedge clk);
    chk("fsm_state", fsm_state, m_state());
    chk("bd_req", bd_req, e_bd_req);
    chk("bd_addr", bd_addr, e_bd_addr);
    chk("bd_side", bd_side, e_bd_side);
    chk("p_ack", p_ack, e_p_ack);
    chk("pc_ack", pc_ack, e_pc_ack);
    chk("timeout", timeout, e_timeout);
    chk("turn", turn, e_turn);
    chk("hits_p", hits_p, 8'(m_hits[0]));
    chk("hits_pc", hits_pc, 8'(m_hits[1]));
    chk("winner", winner, e_winner);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic shoot(input bit who, input logic [5:0] c, input int waitc, input bit hit);
    if (who) begin pc_req = 1'b1; pc_coord = c; end
    else begin p_req = 1'b1; p_coord = c; end
    tick();
    p_req = 1'b0; pc_req = 1'b0;
    repeat (waitc) tick();
    bd_ack = 1'b1; bd_hit = hit;
    tick();
    bd_ack = 1'b0; bd_hit = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(); tick();
    chk("rst_state", fsm_state, 3'd0);
    chk("rst_bd_req", bd_req, 1'b0);
    chk("rst_hits_p", hits_p, 4'd0);
    chk("rst_winner", winner, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b1;
    tick();
    chk("idle_wait", fsm_state, 3'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_state", fsm_state, 3'd1);
    chk("start_turn", turn, 1'b0);

    // Player hit on 6'o23
    p_req = 1'b1; p_coord = 6'o23; tick(); p_req = 1'b0;
    tick();
    chk("look_addr", bd_addr, 6'o23);
    chk("look_side", bd_side, 1'b0);
    chk("look_req", bd_req, 1'b1);
    chk("look_state", fsm_state, 3'd2);
    bd_ack = 1'b1; bd_hit = 1'b1; tick(); bd_ack = 1'b0; bd_hit = 1'b0;
    chk("hit_p_ack", p_ack, 1'b1);
    chk("hit_hits_p", hits_p, 4'd1);
    chk("hit_turn", turn, 1'b0);
    chk("hit_state", fsm_state, 3'd1);
    tick();
    chk("ack_pulse_end", p_ack, 1'b0);
    chk("req_dropped", bd_req, 1'b0);

    // Second hit wins; game over ignores shots until start
    shoot(1'b0, 6'o45, 0, 1'b1);
    chk("win_winner", winner, 2'b01);
    chk("win_state", fsm_state, 3'd5);
    chk("win_hits_p", hits_p, 4'd2);
    shoot(1'b0, 6'o11, 1, 1'b1);
    chk("over_no_ack", p_ack, 1'b0);
    chk("over_hits", hits_p, 4'd2);
    chk("over_bd_req", bd_req, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_hits", hits_p, 4'd0);
    chk("restart_winner", winner, 2'b00);
    chk("restart_turn", turn, 1'b0);
    chk("restart_state", fsm_state, 3'd1);

    // Timeout exactly TC cycles after entering each turn
    repeat (7) tick();
    chk("to_early", timeout, 1'b0);
    tick();
    chk("to_pulse1", timeout, 1'b1);
    chk("to_turn1", turn, 1'b1);
    chk("to_state1", fsm_state, 3'd3);
    repeat (7) tick();
    chk("to_early2", timeout, 1'b0);
    tick();
    chk("to_pulse2", timeout, 1'b1);
    chk("to_turn2", turn, 1'b0);

    // Wrong-side request ignored; request at timer expiry beats the timeout
    pc_req = 1'b1; pc_coord = 6'o66;
    repeat (7) tick();
    chk("pcreq_no_ack", pc_ack, 1'b0);
    chk("pcreq_no_bd", bd_req, 1'b0);
    chk("pcreq_state", fsm_state, 3'd1);
    pc_req = 1'b0; p_req = 1'b1; p_coord = 6'o07;
    tick();
    p_req = 1'b0;
    chk("race_no_to", timeout, 1'b0);
    chk("race_state", fsm_state, 3'd2);
    chk("race_addr", bd_addr, 6'o07);

    // Player miss hands over; PC hit; reset lands mid-lookup
    bd_ack = 1'b1; bd_hit = 1'b0; tick(); bd_ack = 1'b0;
    chk("miss_state", fsm_state, 3'd3);
    chk("miss_turn", turn, 1'b1);
    chk("miss_p_ack", p_ack, 1'b1);
    shoot(1'b1, 6'o70, 0, 1'b1);
    chk("pchit_hits", hits_pc, 4'd1);
    chk("pchit_ack", pc_ack, 1'b1);
    chk("pchit_state", fsm_state, 3'd3);
    pc_req = 1'b1; pc_coord = 6'o52; tick(); pc_req = 1'b0;
    chk("pclook_state", fsm_state, 3'd4);
    chk("pclook_side", bd_side, 1'b1);
    chk("pclook_addr", bd_addr, 6'o52);
    bd_ack = 1'b1; bd_hit = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_bd_req", bd_req, 1'b0);
    chk("arst_state", fsm_state, 3'd0);
    chk("arst_hits_pc", hits_pc, 4'd0);
    chk("arst_side", bd_side, 1'b0);
    chk("arst_addr", bd_addr, 6'd0);
    chk("arst_turn", turn, 1'b0);
    tick(); tick();
    bd_ack = 1'b0; bd_hit = 1'b0; rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", fsm_state, 3'd0);
    chk("post_rst_hits", hits_pc, 4'd0);

    // PC wins; long lookup never times out; turn holds in game over
    start = 1'b1; tick(); start = 1'b0;
    shoot(1'b0, 6'o01, 0, 1'b0);
    chk("pcg_turn", turn, 1'b1);
    shoot(1'b1, 6'o33, 12, 1'b1);
    chk("pcg_hits1", hits_pc, 4'd1);
    chk("pcg_state1", fsm_state, 3'd3);
    shoot(1'b1, 6'o34, 1, 1'b1);
    chk("pcg_winner", winner, 2'b10);
    chk("pcg_state", fsm_state, 3'd5);
    chk("pcg_hits2", hits_pc, 4'd2);
    repeat (3) tick();
    chk("pcg_turn_hold", turn, 1'b1);
    chk("pcg_state_hold", fsm_state, 3'd5);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 The block SHALL have parameter TURN_CYCLES, default 50_000_000, meaning clock cycles allowed per turn before timeout (minimum 2).
REQ-002 The block SHALL have parameter SHIPS, default 5, meaning hits needed to win (1..15).
REQ-003 clk  in  1  sole clock; all flops on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; asserting it immediately forces the reset state of REQ-022.
REQ-005 start  in  1  level; begins a game from IDLE or GAME_OVER.
REQ-006 p_req  in  1  player shot request; p_coord  in  6  target {row[5:3], col[2:0]}.
REQ-007 pc_req  in  1  PC shot request; pc_coord  in  6  target, same format.
REQ-008 bd_req  out  1  board lookup request; bd_addr  out  6  lookup coordinate; bd_side  out  1  board queried (0 = PC board, i.e. player shooting; 1 = player board).
REQ-009 bd_ack  in  1  board lookup done; bd_hit  in  1  lookup result, valid only with bd_ack.
REQ-010 p_ack  out  1 and pc_ack  out  1  one-cycle shot-accepted pulses.
REQ-011 turn  out  1  0 = player's turn, 1 = PC's turn.
REQ-012 timeout  out  1  one-cycle pulse when a turn expires.
REQ-013 hits_p  out  4 and hits_pc  out  4  hits scored by player / PC.
REQ-014 winner  out  2  00 none, 01 player, 10 PC.
REQ-015 fsm_state  out  3  current state encoding, for display and debug.

Function
REQ-016 The FSM SHALL have states IDLE=000, P_TURN=001, P_LOOK=010, PC_TURN=011, PC_LOOK=100, GAME_OVER=101; other encodings SHALL go to IDLE on the next clock.
REQ-017 IDLE or GAME_OVER with start=1 SHALL go to P_TURN on the next clock, clear hits_p, hits_pc and winner, and load the timer.
REQ-018 Timer: load TURN_CYCLES-1 on every entry to P_TURN/PC_TURN; decrement each cycle in those states; hold otherwise. Width is $clog2(TURN_CYCLES).
REQ-019 In P_TURN:
- p_req=1: latch p_coord, go to P_LOOK.
- else if timer=0: pulse timeout, go to PC_TURN.
- A request in the same cycle as timer=0 SHALL win; no timeout pulse.
- pc_req SHALL be ignored and never acked.
PC_TURN is symmetric using pc_req/pc_coord, and times out to P_TURN.
REQ-020 In P_LOOK/PC_LOOK:
- bd_req=1, bd_addr=latched coordinate, bd_side=0 in P_LOOK and 1 in PC_LOOK, all held stable until bd_ack.
- bd_req SHALL drop in the cycle after bd_ack.
- Requester's ack SHALL pulse in the cycle after bd_ack.
- No timeout while waiting.
REQ-021 On bd_ack in a LOOK state:
- hit: increment the shooter's count (saturating at 15). If the new count equals SHIPS, go to GAME_OVER and set winner. Otherwise return to the same shooter's TURN state with the timer reloaded.
- miss: go to the other side's TURN state.
- turn SHALL be 0 in P_TURN/P_LOOK and 1 in PC_TURN/PC_LOOK; in IDLE/GAME_OVER it SHALL hold its last value.
- GAME_OVER SHALL ignore p_req, pc_req and bd_ack until start.

Reset
REQ-022 With rst=0 the block SHALL drive: state IDLE, timer 0, bd_req 0, bd_addr 0, bd_side 0, p_ack 0, pc_ack 0, timeout 0, turn 0, hits_p 0, hits_pc 0, winner 00, fsm_state 000.
REQ-023 Reset asserted mid-lookup SHALL drop bd_req immediately and discard the pending result; after release the block SHALL wait in IDLE for start.

Verification (TURN_CYCLES=8, SHIPS=2)
REQ-024 Reset, start pulse, p_req with p_coord=6'o23, bd_ack+bd_hit two cycles later -> bd_addr=6'o23, bd_side=0, p_ack pulse, hits_p=1, turn stays 0.
REQ-025 start, no requests -> timeout pulses exactly 8 cycles after entering P_TURN, turn=1; a further 8 idle cycles -> timeout pulses again, turn=0.
REQ-026 In P_TURN, p_req asserted on the cycle the timer reaches 0 -> no timeout pulse, FSM goes to P_LOOK; in P_TURN, pc_req=1 -> no pc_ack and no bd_req.
REQ-027 Player: hit, hit -> winner=01, fsm_state=101; later p_req/bd_ack -> no ack and no count change; start -> counts cleared, turn=0.
REQ-028 Player miss -> PC_TURN; PC hit then rst=0 while bd_req=1 -> bd_req=0 in the same cycle, all outputs at REQ-022 values, IDLE after release.
